// File: rtl/barrel_shifter32.sv
// 32-bit registered barrel shifter: SRA / SRL / SLL selected by aluc, built
// from five fixed-distance stages so no variable-amount shift is ever inferred.
module barrel_shifter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c
);

    localparam int unsigned DATA_W = 32;

    logic              w_left;
    logic              w_fill;
    logic [DATA_W-1:0] w_s0;
    logic [DATA_W-1:0] w_s1;
    logic [DATA_W-1:0] w_s2;
    logic [DATA_W-1:0] w_s3;
    logic [DATA_W-1:0] w_s4;
    logic [DATA_W-1:0] w_s5;
    logic [DATA_W-1:0] r_c;

    // aluc[1] picks left shift; only SRA (00) fills with the sign bit.
    assign w_left = aluc[1];
    assign w_fill = (aluc == 2'b00) ? a[DATA_W-1] : 1'b0;
    assign w_s0   = a;

    assign w_s1 = !b[0] ? w_s0 :
                  w_left ? {w_s0[DATA_W-2:0], 1'b0}
                         : {w_fill, w_s0[DATA_W-1:1]};

    assign w_s2 = !b[1] ? w_s1 :
                  w_left ? {w_s1[DATA_W-3:0], 2'b0}
                         : {{2{w_fill}}, w_s1[DATA_W-1:2]};

    assign w_s3 = !b[2] ? w_s2 :
                  w_left ? {w_s2[DATA_W-5:0], 4'b0}
                         : {{4{w_fill}}, w_s2[DATA_W-1:4]};

    assign w_s4 = !b[3] ? w_s3 :
                  w_left ? {w_s3[DATA_W-9:0], 8'b0}
                         : {{8{w_fill}}, w_s3[DATA_W-1:8]};

    assign w_s5 = !b[4] ? w_s4 :
                  w_left ? {w_s4[DATA_W-17:0], 16'b0}
                         : {{16{w_fill}}, w_s4[DATA_W-1:16]};

    // Single output register; reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
        end else begin
            r_c <= w_s5;
        end
    end

    assign c = r_c;

endmodule

// File: tb/tb_barrel_shifter32.sv
// Directed and randomized checks of barrel_shifter32 against hand-computed
// vectors and an operator-based reference model.
module tb_barrel_shifter32;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] c;

    int n_cmp = 0;
    int n_err = 0;

    barrel_shifter32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .aluc  (aluc),
        .c     (c)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] ra, input logic [4:0] rb,
                                              input logic [1:0] rop);
        case (rop)
            2'b00:   return 32'($signed(ra) >>> rb);
            2'b01:   return ra >> rb;
            default: return ra << rb;
        endcase
    endfunction

    task automatic apply(input logic [31:0] ta, input logic [4:0] tb_, input logic [1:0] top);
        a = ta;
        b = tb_;
        aluc = top;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (c !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async got=%h exp=%h", c, 32'h0);
        end
        a = 32'hDEADBEEF; b = 5'd7; aluc = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (c !== 32'h0) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, c, 32'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'hFFFFFFFF; b = 5'd3; aluc = 2'b01;
        @(posedge clk);
        #1;
        n_cmp++;
        if (c !== 32'h1FFFFFFF) begin
            n_err++;
            $display("FAIL reset_release got=%h exp=%h", c, 32'h1FFFFFFF);
        end
    endtask

    task automatic test_srl();
        vec_t v[5];
        v = '{'{32'hFFFFFFFF, 5'd3,  2'b01, 32'h1FFFFFFF},
              '{32'h55555555, 5'd5,  2'b01, 32'h02AAAAAA},
              '{32'h80000001, 5'd31, 2'b01, 32'h00000001},
              '{32'h12345678, 5'd4,  2'b01, 32'h01234567},
              '{32'hF0000000, 5'd1,  2'b01, 32'h78000000}};
        for (int i = 0; i < 5; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_cmp++;
            if (c !== v[i].exp) begin
                n_err++;
                $display("FAIL srl[%0d] got=%h exp=%h", i, c, v[i].exp);
            end
        end
    endtask

    task automatic test_sra();
        vec_t v[6];
        v = '{'{32'hFFFFFFFF, 5'd3,  2'b00, 32'hFFFFFFFF},
              '{32'h55555555, 5'd5,  2'b00, 32'h02AAAAAA},
              '{32'h80000001, 5'd31, 2'b00, 32'hFFFFFFFF},
              '{32'hF0000000, 5'd4,  2'b00, 32'hFF000000},
              '{32'h80000000, 5'd1,  2'b00, 32'hC0000000},
              '{32'h12345678, 5'd8,  2'b00, 32'h00123456}};
        for (int i = 0; i < 6; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_cmp++;
            if (c !== v[i].exp) begin
                n_err++;
                $display("FAIL sra[%0d] got=%h exp=%h", i, c, v[i].exp);
            end
        end
    endtask

    task automatic test_sll();
        vec_t v[6];
        v = '{'{32'hFFFFFFFF, 5'd3,  2'b11, 32'hFFFFFFF8},
              '{32'h55555555, 5'd5,  2'b10, 32'hAAAAAAA0},
              '{32'h80000001, 5'd31, 2'b10, 32'h80000000},
              '{32'h80000001, 5'd31, 2'b11, 32'h80000000},
              '{32'h12345678, 5'd4,  2'b11, 32'h23456780},
              '{32'h00000001, 5'd16, 2'b10, 32'h00010000}};
        for (int i = 0; i < 6; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_cmp++;
            if (c !== v[i].exp) begin
                n_err++;
                $display("FAIL sll[%0d] got=%h exp=%h", i, c, v[i].exp);
            end
        end
    endtask

    task automatic test_boundaries();
        vec_t v[7];
        v = '{'{32'h80000001, 5'd0,  2'b00, 32'h80000001},
              '{32'h80000001, 5'd0,  2'b01, 32'h80000001},
              '{32'h80000001, 5'd0,  2'b10, 32'h80000001},
              '{32'h80000001, 5'd0,  2'b11, 32'h80000001},
              '{32'h7FFFFFFE, 5'd31, 2'b00, 32'h00000000},
              '{32'h7FFFFFFE, 5'd31, 2'b01, 32'h00000000},
              '{32'h7FFFFFFE, 5'd31, 2'b10, 32'h00000000}};
        for (int i = 0; i < 7; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_cmp++;
            if (c !== v[i].exp) begin
                n_err++;
                $display("FAIL boundary[%0d] got=%h exp=%h", i, c, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        v = '{'{32'hA5A5A5A5, 5'd2,  2'b01, 32'h29696969},
              '{32'hA5A5A5A5, 5'd2,  2'b00, 32'hE9696969},
              '{32'hA5A5A5A5, 5'd2,  2'b10, 32'h96969694},
              '{32'h0000FFFF, 5'd12, 2'b11, 32'h0FFFF000}};
        apply(v[0].a, v[0].b, v[0].op);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (c !== v[i].exp) begin
                n_err++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, c, v[i].exp);
            end
            if (i < 3) begin
                a = v[i+1].a; b = v[i+1].b; aluc = v[i+1].op;
                #3;
                n_cmp++;
                if (c !== v[i].exp) begin
                    n_err++;
                    $display("FAIL b2b_hold[%0d] got=%h exp=%h", i, c, v[i].exp);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(32'hFFFFFFFF, 5'd3, 2'b01);
        n_cmp++;
        if (c !== 32'h1FFFFFFF) begin
            n_err++;
            $display("FAIL midrst_pre got=%h exp=%h", c, 32'h1FFFFFFF);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (c !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_async got=%h exp=%h", c, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (c !== 32'h0) begin
                n_err++;
                $display("FAIL midrst_hold[%0d] got=%h exp=%h", i, c, 32'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'h55555555; b = 5'd5; aluc = 2'b10;
        @(posedge clk);
        #1;
        n_cmp++;
        if (c !== 32'hAAAAAAA0) begin
            n_err++;
            $display("FAIL midrst_release got=%h exp=%h", c, 32'hAAAAAAA0);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [4:0]  rb;
        logic [1:0]  rop;
        logic [31:0] exp;
        for (int i = 0; i < 10000; i++) begin
            ra  = $urandom;
            rb  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            exp = ref_shift(ra, rb, rop);
            apply(ra, rb, rop);
            n_cmp++;
            if (c !== exp) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%0d op=%b got=%h exp=%h",
                         i, ra, rb, rop, c, exp);
            end
        end
    endtask

    initial begin
        a = '0;
        b = '0;
        aluc = '0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_srl();
        test_sra();
        test_sll();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
